// File: rtl/apb_requester.sv
// APB4 requester: accepts single read/write commands over valid/ready, runs each
// through SETUP/ACCESS, and returns a one-cycle response pulse.
// Optional build macro: APB_REQ_TIMEOUT_EN enables the wait-state abort counter.
module apb_requester #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_misalign,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  output logic [2:0]            pprot,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  // Number of address bits that must be zero for a naturally aligned transfer.
  localparam int unsigned LSB_W = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;

  // Reject unsupported configurations at elaboration.
  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32) || TIMEOUT_CYCLES < 1)
  begin : g_bad_cfg
    $error("apb_requester: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic                    mis_pend_q, mis_pend_d;
  logic                    psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_d;
  logic [2:0]              pprot_d;
  logic                    rsp_valid_d, rsp_slverr_d, rsp_misalign_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;
  logic                    accept, misalign, load;

`ifdef APB_REQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_d;
`endif

  assign cmd_ready = (state_q == IDLE) || (state_q == ACCESS && pready);
  assign accept    = cmd_valid && cmd_ready;
  assign misalign  = (STRB_WIDTH > 1) && (cmd_addr[LSB_W-1:0] != '0);
  assign load      = accept && !misalign;

  // Next state, next APB fields and next response.
  always_comb begin
    state_d        = state_q;
    mis_pend_d     = 1'b0;
    psel_d         = psel;
    penable_d      = penable;
    pwrite_d       = pwrite;
    paddr_d        = paddr;
    pwdata_d       = pwdata;
    pstrb_d        = pstrb;
    pprot_d        = pprot;
    rsp_valid_d    = 1'b0;
    rsp_rdata_d    = '0;
    rsp_slverr_d   = 1'b0;
    rsp_misalign_d = 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
    cnt_d          = cnt_q;
    rsp_timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A misalign deferred behind a completion goes first; a new one then waits a cycle.
        if (mis_pend_q || (accept && misalign)) begin
          rsp_valid_d    = 1'b1;
          rsp_slverr_d   = 1'b1;
          rsp_misalign_d = 1'b1;
        end
        mis_pend_d = mis_pend_q && accept && misalign;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          rsp_valid_d  = 1'b1;
          rsp_slverr_d = pslverr;
          rsp_rdata_d  = (!pwrite && !pslverr) ? prdata : '0;
          state_d      = IDLE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          mis_pend_d   = accept && misalign;
        end
`ifdef APB_REQ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d   = SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = cmd_write;
      paddr_d   = cmd_addr;
      pwdata_d  = cmd_wdata;
      pstrb_d   = cmd_write ? cmd_strb : '0;
      pprot_d   = cmd_prot;
`ifdef APB_REQ_TIMEOUT_EN
      cnt_d     = '0;
`endif
    end
  end

  // State and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q      <= IDLE;
      mis_pend_q   <= 1'b0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      pstrb        <= '0;
      pprot        <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_slverr   <= 1'b0;
      rsp_misalign <= 1'b0;
    end else begin
      state_q      <= state_d;
      mis_pend_q   <= mis_pend_d;
      psel         <= psel_d;
      penable      <= penable_d;
      pwrite       <= pwrite_d;
      paddr        <= paddr_d;
      pwdata       <= pwdata_d;
      pstrb        <= pstrb_d;
      pprot        <= pprot_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rsp_rdata_d;
      rsp_slverr   <= rsp_slverr_d;
      rsp_misalign <= rsp_misalign_d;
    end
  end

`ifdef APB_REQ_TIMEOUT_EN
  // Wait-state counter and timeout flag.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q       <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_requester.sv
// Randomized bench for apb_requester: drives commands and an APB completer, and
// predicts bus activity and responses from a transaction-level timing model.
module tb_apb_requester;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
`ifdef APB_REQ_TIMEOUT_EN
  localparam int TO    = 4;
  localparam int MAXW  = TO + 2;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 16;
  localparam int MAXW  = 3;
  localparam bit TO_EN = 1'b0;
`endif
  localparam int NCYC = 3000;
  localparam int NSLOT = NCYC + 64;

  logic          pclk, preset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_slverr, rsp_misalign, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  apb_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_misalign(rsp_misalign), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Transaction-level model: edge of accept, edge of completion, last loaded fields.
  int            act_e, act_c, next_free, last_used;
  logic          act_abort, act_err;
  logic [DW-1:0] act_rdata;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_strb;
  logic [2:0]    m_prot;
  logic [35:0]   exp_rsp [NSLOT];
  logic          taken;

  task automatic model_reset(input int m);
    for (int s = m; s <= last_used && s < NSLOT; s++) exp_rsp[s] = '0;
    act_e = -10; act_c = -10;
    next_free = m; last_used = m - 1;
    m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_strb = '0; m_prot = '0;
  endtask

  task automatic model_accept(input int m);
    int w, slot;
    taken = 1'b1;
    if (cmd_addr[1:0] != 2'b00) begin
      slot = (m > last_used + 1) ? m : last_used + 1;
      exp_rsp[slot] = {1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
      last_used = slot;
    end else begin
      w         = $urandom_range(0, MAXW);
      act_abort = TO_EN && (w > TO);
      act_e     = m;
      act_c     = m + 2 + (act_abort ? TO : w);
      next_free = act_abort ? act_c + 1 : act_c;
      act_rdata = $urandom;
      act_err   = ($urandom_range(0, 3) == 0);
      m_wr = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
      m_strb = cmd_write ? cmd_strb : 4'h0; m_prot = cmd_prot;
      if (act_abort) exp_rsp[act_c] = {1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
      else exp_rsp[act_c] = {1'b1, act_err, 1'b0, 1'b0, (!cmd_write && !act_err) ? act_rdata : 32'h0};
      last_used = act_c;
    end
  endtask

  initial begin
    logic [73:0] eb;
    logic [31:0] tmp;
    logic        busy, rst;
    int          m;
    preset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0; taken = 1'b0;
    for (int s = 0; s < NSLOT; s++) exp_rsp[s] = '0;
    last_used = -1;
    model_reset(0);
    repeat (3) @(posedge pclk);
    for (int n = 0; n < NCYC; n++) begin
      @(negedge pclk);
      cyc  = n;
      busy = (n >= act_e) && (n < act_c);
      eb   = {busy, busy && (n > act_e), m_wr, m_addr, m_wdata, m_strb, m_prot};
      check("bus", 128'({psel, penable, pwrite, paddr, pwdata, pstrb, pprot}), 128'(eb));
      check("rsp", 128'({rsp_valid, rsp_slverr, rsp_misalign, rsp_timeout, rsp_rdata}),
            128'(exp_rsp[n]));
      m = n + 1;
      if (taken) begin cmd_valid = 1'b0; taken = 1'b0; end
      rst = (n > 20) && ($urandom_range(0, 149) == 0);
      if (rst) begin
        preset = 1'b1; cmd_valid = 1'b0;
      end else begin
        preset = 1'b0;
        if (!cmd_valid && $urandom_range(0, 9) < 7) begin
          tmp       = $urandom;
          cmd_addr  = {tmp[31:2], ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
          cmd_write = 1'($urandom_range(0, 1));
          cmd_wdata = $urandom;
          cmd_strb  = 4'($urandom_range(0, 15));
          cmd_prot  = 3'($urandom_range(0, 7));
          cmd_valid = 1'b1;
        end
      end
      if (m == act_c && !act_abort) begin
        pready = 1'b1; prdata = act_rdata; pslverr = act_err;
      end else if (m >= act_e + 2 && m <= act_c) begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      end else begin
        pready = 1'($urandom_range(0, 1)); prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      end
      #1;
      check("cmd_ready", 128'(cmd_ready), 128'(m >= next_free));
      if (rst) model_reset(m);
      else if (cmd_valid && m >= next_free) model_accept(m);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
